// File: rtl/pio_gpio_pkg.sv
// Shared constants for the parametrised GPIO block: register map and
// edge/interrupt mode encodings.
package pio_gpio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned BUS_W  = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_DIR     = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR  = 3'd5;

  localparam int unsigned EDGE_RISING  = 0;
  localparam int unsigned EDGE_FALLING = 1;
  localparam int unsigned EDGE_ANY     = 2;

  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_gpio_insync.sv
// Input synchroniser chain, one-cycle history flop, post-reset warm-up
// counter and edge-detect vector for the GPIO block.
module pio_gpio_insync
  import pio_gpio_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = EDGE_RISING
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] in_sync,
  output logic [WIDTH-1:0] edge_det
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SYNC_STAGES + 1);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] warm_cnt;
  logic             warm_done;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      prev_q   <= '0;
      warm_cnt <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      if (!warm_done) warm_cnt <= warm_cnt + CNT_W'(1);
    end
  end

  assign in_sync   = sync_q[SYNC_STAGES-1];
  assign warm_done = (warm_cnt == CNT_MAX);
  assign rise      = in_sync & ~prev_q;
  assign fall      = ~in_sync & prev_q;

  // Edges are masked until the chain has flushed its reset zeros.
  always_comb begin
    edge_raw = rise;
    case (EDGE_TYPE)
      EDGE_FALLING: edge_raw = fall;
      EDGE_ANY:     edge_raw = rise | fall;
      default:      edge_raw = rise;
    endcase
  end

  assign edge_det = warm_done ? edge_raw : '0;

endmodule

// File: rtl/pio_gpio_ctrl.sv
// Avalon-MM GPIO slave: data/direction/irqmask/edgecapture registers,
// atomic set/clear of outputs, zero-latency read mux and registered irq.
module pio_gpio_ctrl
  import pio_gpio_pkg::*;
#(
  parameter int unsigned       WIDTH       = 32,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  parameter int unsigned       SYNC_STAGES = 2,
  parameter int unsigned       EDGE_TYPE   = EDGE_RISING,
  parameter int unsigned       IRQ_TYPE    = IRQ_EDGE
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe_port,
  output logic             irq
);

  logic             wr;
  logic [WIDTH-1:0] wd;
  logic             unused_wd;
  logic [WIDTH-1:0] data_out;
  logic [WIDTH-1:0] direction;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] edgecap_clr;
  logic [WIDTH-1:0] in_sync;
  logic [WIDTH-1:0] edge_det;
  logic             irq_src;
  logic [WIDTH-1:0] rd_c;

  assign wr        = chipselect & ~write_n;
  assign wd        = writedata[WIDTH-1:0];
  assign unused_wd = ^writedata;

  pio_gpio_insync #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .EDGE_TYPE   (EDGE_TYPE)
  ) u_insync (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_port  (in_port),
    .in_sync  (in_sync),
    .edge_det (edge_det)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out  <= RESET_VALUE;
      direction <= '0;
      irqmask   <= '0;
    end else if (wr) begin
      case (address)
        ADDR_DATA:    data_out  <= wd;
        ADDR_DIR:     direction <= wd;
        ADDR_IRQMASK: irqmask   <= wd;
        ADDR_OUTSET:  data_out  <= data_out | wd;
        ADDR_OUTCLR:  data_out  <= data_out & ~wd;
        default:      ;
      endcase
    end
  end

  // A fresh edge in the same cycle as a write-1-to-clear keeps the bit set.
  assign edgecap_clr = (wr && address == ADDR_EDGECAP) ? wd : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) edgecap <= '0;
    else          edgecap <= edge_det | (edgecap & ~edgecap_clr);
  end

  assign irq_src = (IRQ_TYPE == IRQ_EDGE) ? |(edgecap & irqmask)
                                          : |(in_sync & irqmask & ~direction);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) irq <= 1'b0;
    else          irq <= irq_src;
  end

  always_comb begin
    rd_c = '0;
    case (address)
      ADDR_DATA:    rd_c = (direction & data_out) | (~direction & in_sync);
      ADDR_DIR:     rd_c = direction;
      ADDR_IRQMASK: rd_c = irqmask;
      ADDR_EDGECAP: rd_c = edgecap;
      default:      rd_c = '0;
    endcase
  end

  assign readdata = BUS_W'(rd_c);
  assign out_port = data_out;
  assign oe_port  = direction;

endmodule

// File: doc/pio_gpio_ctrl.md
Name: pio_gpio_ctrl

Overview:
Parametrised Avalon-MM slave general-purpose I/O block, successor to the fixed 4-bit output-only PIO. Provides per-bit direction, atomic set/clear of outputs, synchronised inputs with edge capture, and a maskable interrupt. Sits on the system interconnect. Drives board-level pins through separate out/oe/in buses; the tristate buffers live at top level.

Parameters:
WIDTH, 32, number of I/O bits (1..32)
RESET_VALUE, 0, data_out value after reset (WIDTH bits)
SYNC_STAGES, 2, input synchroniser depth (2..4)
EDGE_TYPE, 0, edge capture mode: 0 rising, 1 falling, 2 any
IRQ_TYPE, 1, interrupt source: 0 level (masked inputs), 1 edge (masked edgecapture)

Ports:
clk  in  1  system clock
reset_n  in  1  reset: reset_n, asynchronous, active-low; clock clk
address  in  3  register select
chipselect  in  1  slave select
write_n  in  1  active-low write strobe
writedata  in  32  write data
readdata  out  32  read data, zero read latency (combinational from registers)
in_port  in  WIDTH  asynchronous pin inputs
out_port  out  WIDTH  output data
oe_port  out  WIDTH  per-bit output enable (= direction register)
irq  out  1  registered interrupt request

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Writes take effect at the next clk edge.
- Register map. Bits above WIDTH read 0; unused addresses 6-7 read 0 and ignore writes:
  - 0 DATA: write sets data_out. Read gives per bit direction ? data_out : in_sync.
  - 1 DIRECTION: R/W; 1 = output.
  - 2 IRQMASK: R/W.
  - 3 EDGECAPTURE: read returns captured edges; write-1-to-clear.
  - 4 OUTSET: write-only; data_out |= wd. Reads 0.
  - 5 OUTCLEAR: write-only; data_out &= ~wd. Reads 0.
- Reset values: data_out = RESET_VALUE; direction, irqmask, edgecapture, synchroniser flops, prev flop, irq and warm-up counter all 0. out_port = RESET_VALUE; oe_port = 0; readdata follows registers.
- Synchroniser: in_port passes through SYNC_STAGES flops to give in_sync. prev is in_sync delayed by one cycle.
- Edge detect:
  - rising = in_sync & ~prev; falling = ~in_sync & prev; any = their OR. Selected by EDGE_TYPE.
  - Detection is applied to all bits regardless of direction.
- Warm-up:
  - A counter of width clog2(SYNC_STAGES+2) counts from 0 to SYNC_STAGES+1 after reset deassertion, then saturates.
  - Edge capture is suppressed until the counter saturates, so pins already high at reset produce no spurious edge.
- Edgecapture update, per bit each cycle:
  - set if an edge is detected (after warm-up);
  - else clear if wr at address 3 with wd bit = 1;
  - else hold.
  - A simultaneous set and clear leaves the bit set (set wins).
- Latency: an in_port change ahead of clk edge k appears in in_sync after edge k+SYNC_STAGES-1. The edgecapture bit is set at edge k+SYNC_STAGES. irq asserts at edge k+SYNC_STAGES+1.
- irq:
  - Registered each cycle.
  - IRQ_TYPE 1: irq <= |(edgecapture & irqmask).
  - IRQ_TYPE 0: irq <= |(in_sync & irqmask & ~direction).
  - Deasserts one cycle after the source clears or is masked.
- Reset mid-operation: asynchronous return to the reset values above; warm-up restarts.

Decomposition:
- Package pio_gpio_pkg:
  - address constants ADDR_DATA=0, ADDR_DIR=1, ADDR_IRQMASK=2, ADDR_EDGECAP=3, ADDR_OUTSET=4, ADDR_OUTCLR=5;
  - EDGE_RISING/EDGE_FALLING/EDGE_ANY encodings;
  - IRQ_LEVEL/IRQ_EDGE encodings.
- Sub-module pio_gpio_insync: WIDTH-wide synchroniser chain, prev flop, warm-up counter and edge-detect vector output. The top level holds the register file, read mux and irq.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=0xA5 -> out_port=0xA5, oe_port=0x00, irq=0, reads of addrs 1-3 return 0.
- Write DATA=0xF0, OUTSET=0x0F, OUTCLEAR=0x81 -> out_port 0xF0, 0xFF, 0x7E on successive cycles; reads of addr 4/5 return 0.
- DIRECTION=0x0F, data_out=0x05, in_port=0xA0 -> DATA read = 0xA5.
- EDGE_TYPE=0, IRQ_TYPE=1, IRQMASK=0x01, in_port[0] 0->1 before edge 0 -> edgecapture=0x01 after edge 2, irq=1 after edge 3; write 0x01 to addr 3 -> irq=0 two edges later.
- Same cycle: new edge on bit 0 and write-1-clear of bit 0 -> edgecapture[0] remains 1.
- in_port=0xFF held through reset release -> edgecapture stays 0 for 20 cycles; IRQ_TYPE=0, IRQMASK=0x02 -> irq=1 SYNC_STAGES+1 edges after in_port[1] rises.
